// File: rtl/cr_mc_sync_fifo.sv
// Single-clock multi-channel FIFO: N_CHANNELS queues, each with its own static partition
// of N_ENTRIES words, sharing one write port and one read port.
module cr_mc_sync_fifo #(
    parameter int N_DATA_BITS  = 64,
    parameter int N_ENTRIES    = 8,
    parameter int N_CHANNELS   = 4,
    parameter int N_AFULL_VAL  = 1,
    parameter int N_AEMPTY_VAL = 1,
    parameter int RD_LATENCY   = 0,
    localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int UW = $clog2(N_ENTRIES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wen,
    input  logic [CW-1:0]            wch,
    input  logic [N_DATA_BITS-1:0]   wdata,
    input  logic                     ren,
    input  logic [CW-1:0]            rch,
    output logic [N_DATA_BITS-1:0]   rdata,
    output logic                     rvalid,
    output logic [N_CHANNELS-1:0]    full,
    output logic [N_CHANNELS-1:0]    afull,
    output logic [N_CHANNELS-1:0]    empty,
    output logic [N_CHANNELS-1:0]    aempty,
    output logic [N_CHANNELS*UW-1:0] used_slots,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    logic [N_DATA_BITS-1:0] mem_q  [N_CHANNELS][N_ENTRIES];
    logic [PW-1:0]          wptr_q [N_CHANNELS];
    logic [PW-1:0]          rptr_q [N_CHANNELS];
    logic [UW-1:0]          cnt_q  [N_CHANNELS];
    logic                   overflow_q;
    logic                   underflow_q;

    logic                   wch_ok;
    logic                   rch_ok;
    logic [CW-1:0]          wr_idx;
    logic [CW-1:0]          rd_idx;
    logic                   head_vld;
    logic                   rd_acc;
    logic                   wr_acc;
    logic [N_CHANNELS-1:0]  wr_hit;
    logic [N_CHANNELS-1:0]  rd_hit;
    logic [N_DATA_BITS-1:0] head_w;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(N_ENTRIES - 1)) ? '0 : p + PW'(1);
    endfunction

    // Out-of-range channel ids are steered to channel 0 for indexing only; the
    // *_ok qualifiers keep them from being accepted.
    assign wch_ok   = (int'(wch) < N_CHANNELS);
    assign rch_ok   = (int'(rch) < N_CHANNELS);
    assign wr_idx   = wch_ok ? wch : '0;
    assign rd_idx   = rch_ok ? rch : '0;
    assign head_vld = rch_ok & ~empty[rd_idx];
    assign head_w   = mem_q[rd_idx][rptr_q[rd_idx]];

    // A full channel still accepts a write when it is popped in the same cycle.
    assign rd_acc = ren & head_vld;
    assign wr_acc = wen & wch_ok & (~full[wr_idx] | (rd_acc & (rch == wch)));

    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            wr_hit[c] = wr_acc & (wr_idx == CW'(c));
            rd_hit[c] = rd_acc & (rd_idx == CW'(c));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= wen & ~wr_acc;
            underflow_q <= ren & ~rd_acc;
            for (int c = 0; c < N_CHANNELS; c++) begin
                if (wr_hit[c]) wptr_q[c] <= ptr_inc(wptr_q[c]);
                if (rd_hit[c]) rptr_q[c] <= ptr_inc(rptr_q[c]);
                if (wr_hit[c] && !rd_hit[c])
                    cnt_q[c] <= cnt_q[c] + UW'(1);
                else if (rd_hit[c] && !wr_hit[c])
                    cnt_q[c] <= cnt_q[c] - UW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc)
            mem_q[wr_idx][wptr_q[wr_idx]] <= wdata;
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_flag
        logic [UW:0] used_x;
        logic [UW:0] free_x;
        assign used_x    = {1'b0, cnt_q[c]};
        assign free_x    = (UW+1)'(N_ENTRIES) - used_x;
        assign empty[c]  = (used_x == '0);
        assign full[c]   = (used_x == (UW+1)'(N_ENTRIES));
        assign afull[c]  = (free_x <= (UW+1)'(N_AFULL_VAL));
        assign aempty[c] = (used_x <= (UW+1)'(N_AEMPTY_VAL));
        assign used_slots[c*UW +: UW] = cnt_q[c];
    end

    if (RD_LATENCY == 0) begin : g_fall_through
        assign rdata  = head_vld ? head_w : '0;
        assign rvalid = 1'b0;
    end else begin : g_registered
        logic [N_DATA_BITS-1:0] rdata_q;
        logic                   rvalid_q;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) rdata_q <= head_w;
            end
        end
        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end

endmodule

// File: tb/tb_cr_mc_sync_fifo.sv
// Directed bench: dut0 is the default fall-through FIFO (4 ch x 8), dut1 a registered-read
// FIFO with 3 channels x 5 entries so id 3 is out of range and pointers wrap quickly.
module tb_cr_mc_sync_fifo;

    logic        clk;
    logic        rst_n;
    logic        wen;
    logic [1:0]  wch;
    logic [63:0] wdata;
    logic        ren;
    logic [1:0]  rch;

    logic [63:0] rdata0, rdata1;
    logic        rvalid0, rvalid1;
    logic [3:0]  full0, afull0, empty0, aempty0;
    logic [2:0]  full1, afull1, empty1, aempty1;
    logic [15:0] used0;
    logic [8:0]  used1;
    logic        overflow0, underflow0, overflow1, underflow1;

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] sb [3][$];

    cr_mc_sync_fifo u_dut0 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wch(wch), .wdata(wdata),
        .ren(ren), .rch(rch), .rdata(rdata0), .rvalid(rvalid0),
        .full(full0), .afull(afull0), .empty(empty0), .aempty(aempty0),
        .used_slots(used0), .overflow(overflow0), .underflow(underflow0)
    );

    cr_mc_sync_fifo #(.N_ENTRIES(5), .N_CHANNELS(3), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wch(wch), .wdata(wdata),
        .ren(ren), .rch(rch), .rdata(rdata1), .rvalid(rvalid1),
        .full(full1), .afull(afull1), .empty(empty1), .aempty(aempty1),
        .used_slots(used1), .overflow(overflow1), .underflow(underflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (empty0 !== 4'hF) $display("FAIL reset_empty0: got %h exp f", empty0); else n_pass++;
        n_total++; if (aempty0 !== 4'hF) $display("FAIL reset_aempty0: got %h exp f", aempty0); else n_pass++;
        n_total++; if (full0 !== 4'h0) $display("FAIL reset_full0: got %h exp 0", full0); else n_pass++;
        n_total++; if (afull0 !== 4'h0) $display("FAIL reset_afull0: got %h exp 0", afull0); else n_pass++;
        n_total++; if (used0 !== 16'h0) $display("FAIL reset_used0: got %h exp 0", used0); else n_pass++;
        n_total++; if ({overflow0, underflow0, rvalid0} !== 3'b000) $display("FAIL reset_pulses0: got %b exp 000", {overflow0, underflow0, rvalid0}); else n_pass++;
        n_total++; if (rdata0 !== 64'h0) $display("FAIL reset_rdata0: got %h exp 0", rdata0); else n_pass++;
        n_total++; if ({empty1, aempty1, full1, afull1} !== 12'hFC0) $display("FAIL reset_flags1: got %h exp fc0", {empty1, aempty1, full1, afull1}); else n_pass++;
        n_total++; if ({rvalid1, rdata1} !== 65'h0) $display("FAIL reset_rdata1: got %b/%h exp 0/0", rvalid1, rdata1); else n_pass++;
        step();
        n_total++; if ({overflow0, underflow0, used0} !== 18'h0) $display("FAIL idle0: got %h exp 0", {overflow0, underflow0, used0}); else n_pass++;
    endtask

    task automatic test_fill_ch2();
        for (int i = 0; i < 8; i++) begin
            wen = 1'b1; wch = 2'd2; wdata = 64'h10 + 64'(i);
            step();
            n_total++; if (used0[8 +: 4] !== 4'(i + 1)) $display("FAIL fill_used[%0d]: got %0d exp %0d", i, used0[8 +: 4], i + 1); else n_pass++;
            n_total++; if (afull0[2] !== (i + 1 >= 7)) $display("FAIL fill_afull[%0d]: got %b exp %b", i, afull0[2], (i + 1 >= 7)); else n_pass++;
            n_total++; if (full0[2] !== (i + 1 == 8)) $display("FAIL fill_full[%0d]: got %b exp %b", i, full0[2], (i + 1 == 8)); else n_pass++;
        end
        wdata = 64'h99;
        step();
        idle();
        n_total++; if (overflow0 !== 1'b1) $display("FAIL overflow_pulse: got %b exp 1", overflow0); else n_pass++;
        n_total++; if (used0[8 +: 4] !== 4'd8) $display("FAIL overflow_used: got %0d exp 8", used0[8 +: 4]); else n_pass++;
        step();
        n_total++; if (overflow0 !== 1'b0) $display("FAIL overflow_clear: got %b exp 0", overflow0); else n_pass++;
    endtask

    task automatic test_full_same_cycle();
        wen = 1'b1; wch = 2'd2; wdata = 64'hAA;
        ren = 1'b1; rch = 2'd2;
        #1;
        n_total++; if (rdata0 !== 64'h10) $display("FAIL fullrw_head: got %h exp 10", rdata0); else n_pass++;
        step();
        idle();
        n_total++; if ({overflow0, underflow0} !== 2'b00) $display("FAIL fullrw_err: got %b exp 00", {overflow0, underflow0}); else n_pass++;
        n_total++; if (used0[8 +: 4] !== 4'd8) $display("FAIL fullrw_used: got %0d exp 8", used0[8 +: 4]); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            logic [63:0] exp_d;
            exp_d = (i == 7) ? 64'hAA : 64'h11 + 64'(i);
            ren = 1'b1; rch = 2'd2;
            #1;
            n_total++; if (rdata0 !== exp_d) $display("FAIL drain_data[%0d]: got %h exp %h", i, rdata0, exp_d); else n_pass++;
            step();
            n_total++; if (aempty0[2] !== (7 - i <= 1)) $display("FAIL drain_aempty[%0d]: got %b exp %b", i, aempty0[2], (7 - i <= 1)); else n_pass++;
        end
        idle();
        n_total++; if ({empty0[2], used0[8 +: 4]} !== 5'b10000) $display("FAIL drain_empty: got %b exp 10000", {empty0[2], used0[8 +: 4]}); else n_pass++;
        ren = 1'b1; rch = 2'd2;
        #1;
        n_total++; if (rdata0 !== 64'h0) $display("FAIL empty_rdata: got %h exp 0", rdata0); else n_pass++;
        step();
        idle();
        n_total++; if (underflow0 !== 1'b1) $display("FAIL empty_underflow: got %b exp 1", underflow0); else n_pass++;
    endtask

    task automatic test_empty_same_cycle();
        wen = 1'b1; wch = 2'd1; wdata = 64'h55;
        ren = 1'b1; rch = 2'd1;
        #1;
        n_total++; if (rdata0 !== 64'h0) $display("FAIL emptyrw_rdata: got %h exp 0", rdata0); else n_pass++;
        step();
        idle();
        n_total++; if ({underflow0, overflow0} !== 2'b10) $display("FAIL emptyrw_err: got %b exp 10", {underflow0, overflow0}); else n_pass++;
        n_total++; if (used0[4 +: 4] !== 4'd1) $display("FAIL emptyrw_used: got %0d exp 1", used0[4 +: 4]); else n_pass++;
        ren = 1'b1; rch = 2'd1;
        #1;
        n_total++; if (rdata0 !== 64'h55) $display("FAIL emptyrw_data: got %h exp 55", rdata0); else n_pass++;
        step();
        idle();
        n_total++; if ({underflow0, used0[4 +: 4]} !== 5'b00000) $display("FAIL emptyrw_after: got %b exp 00000", {underflow0, used0[4 +: 4]}); else n_pass++;
    endtask

    task automatic test_interleave();
        do_reset();
        for (int c = 0; c < 3; c++) sb[c].delete();
        for (int i = 0; i < 30; i++) begin
            logic        rd_ok, wr_ok;
            logic [63:0] exp_d;
            wen = 1'b1; wch = 2'(i % 4); wdata = 64'h200 + 64'(i);
            ren = (i % 3 != 0); rch = 2'((i / 2) % 4);
            exp_d = '0;
            rd_ok = ren && (rch < 2'd3) && (sb[rch].size() > 0);
            wr_ok = wen && (wch < 2'd3) && ((sb[wch].size() < 5) || (rd_ok && rch == wch));
            if (rd_ok) exp_d = sb[rch].pop_front();
            if (wr_ok) sb[wch].push_back(wdata);
            step();
            n_total++; if (rvalid1 !== rd_ok) $display("FAIL il_rvalid[%0d]: got %b exp %b", i, rvalid1, rd_ok); else n_pass++;
            if (rd_ok) begin
                n_total++; if (rdata1 !== exp_d) $display("FAIL il_rdata[%0d]: got %h exp %h", i, rdata1, exp_d); else n_pass++;
            end
            n_total++; if ({overflow1, underflow1} !== {wen && !wr_ok, ren && !rd_ok})
                $display("FAIL il_err[%0d]: got %b exp %b", i, {overflow1, underflow1}, {wen && !wr_ok, ren && !rd_ok}); else n_pass++;
            for (int c = 0; c < 3; c++) begin
                n_total++; if (used1[c*3 +: 3] !== 3'(sb[c].size())) $display("FAIL il_used[%0d][%0d]: got %0d exp %0d", i, c, used1[c*3 +: 3], sb[c].size()); else n_pass++;
            end
        end
        wen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            while (sb[c].size() > 0) begin
                logic [63:0] exp_d;
                exp_d = sb[c].pop_front();
                ren = 1'b1; rch = 2'(c);
                step();
                n_total++; if ({rvalid1, rdata1} !== {1'b1, exp_d}) $display("FAIL il_drain[%0d]: got %b/%h exp 1/%h", c, rvalid1, rdata1, exp_d); else n_pass++;
            end
        end
        idle();
        step();
        n_total++; if ({empty1, rvalid1} !== 4'b1110) $display("FAIL il_final: got %b exp 1110", {empty1, rvalid1}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wen = 1'b1; wch = 2'd0; wdata = 64'h300 + 64'(i);
            step();
        end
        idle();
        n_total++; if ({used0[3:0], used1[2:0]} !== {4'd3, 3'd3}) $display("FAIL mid_prefill: got %0d/%0d exp 3/3", used0[3:0], used1[2:0]); else n_pass++;
        rst_n = 1'b0;
        wen = 1'b1; wch = 2'd3; wdata = 64'hDEAD;
        ren = 1'b1; rch = 2'd0;
        step();
        rst_n = 1'b1;
        idle();
        n_total++; if ({used0, used1} !== 25'h0) $display("FAIL mid_used: got %h/%h exp 0/0", used0, used1); else n_pass++;
        n_total++; if ({empty0, empty1} !== 7'h7F) $display("FAIL mid_empty: got %h/%h exp f/7", empty0, empty1); else n_pass++;
        n_total++; if ({rvalid1, rdata1} !== 65'h0) $display("FAIL mid_rvalid: got %b/%h exp 0/0", rvalid1, rdata1); else n_pass++;
        n_total++; if ({overflow0, underflow0, overflow1, underflow1} !== 4'b0000)
            $display("FAIL mid_pulses: got %b exp 0000", {overflow0, underflow0, overflow1, underflow1}); else n_pass++;
        step();
        n_total++; if ({used0, used1, rvalid1} !== 26'h0) $display("FAIL mid_idle: got %h exp 0", {used0, used1, rvalid1}); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        wen = 1'b0; wch = '0; wdata = '0;
        ren = 1'b0; rch = '0;
        test_reset();
        test_fill_ch2();
        test_full_same_cycle();
        test_empty_same_cycle();
        test_interleave();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
